// File: rtl/cosim_counter_pkg.sv
// Shared types and helpers for the cosim event counter bank.
// Snapshot FSM states, counter-mode encodings and the read-index width.
package cosim_counter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } snap_state_t;

    localparam int COUNT_WRAP = 0;
    localparam int COUNT_SAT  = 1;

    // Beat index must cover the cycle counter plus every channel.
    function automatic int idx_width(input int num_channels);
        return (num_channels < 1) ? 1 : $clog2(num_channels + 1);
    endfunction

endpackage

// File: rtl/cosim_sat_counter.sv
// Single live counter with clear, increment and wrap-or-saturate at all-ones.
// Sticky overflow flag is raised by any increment attempted at all-ones.
module cosim_sat_counter
    import cosim_counter_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int SATURATE = COUNT_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] value,
    output logic             overflow
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            value    <= '0;
            overflow <= 1'b0;
        end else if (inc) begin
            if (&value) begin
                overflow <= 1'b1;
                value    <= (SATURATE == COUNT_SAT) ? value : '0;
            end else begin
                value <= value + WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/cosim_event_counter_bank.sv
// Cycle counter plus NUM_CHANNELS event counters with an atomic snapshot
// streamed out one counter per beat over a valid/ready read port.
module cosim_event_counter_bank
    import cosim_counter_pkg::*;
#(
    parameter int              NUM_CHANNELS            = 4,
    parameter int              COUNT_WIDTH             = 64,
    parameter int              SATURATE                = COUNT_WRAP,
    parameter longint unsigned CORE_CLOCK_FREQUENCY_HZ = 100_000_000,
    localparam int             IDX_W                   = idx_width(NUM_CHANNELS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [NUM_CHANNELS-1:0] event_in,
    input  logic                    clear,
    input  logic                    snap_req,
    output logic                    snap_busy,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [IDX_W-1:0]        rd_index,
    output logic [COUNT_WIDTH-1:0]  rd_data,
    output logic                    rd_last,
    output logic [NUM_CHANNELS:0]   overflow,
    output logic [63:0]             clock_freq_hz
);

    localparam int              NUM_CNT  = NUM_CHANNELS + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS);

    logic [NUM_CNT-1:0]                  inc;
    logic [NUM_CNT-1:0][COUNT_WIDTH-1:0] live;
    logic [NUM_CNT-1:0][COUNT_WIDTH-1:0] snap;

    snap_state_t      state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic             capture;

    // Slot 0 is the cycle counter, which counts on every enabled edge.
    assign inc = {event_in, 1'b1} & {NUM_CNT{enable}};

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        cosim_sat_counter #(
            .WIDTH    (COUNT_WIDTH),
            .SATURATE (SATURATE)
        ) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .clear    (clear),
            .inc      (inc[i]),
            .value    (live[i]),
            .overflow (overflow[i])
        );
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (snap_req) begin
                    capture   = 1'b1;
                    state_nxt = STREAM;
                    idx_nxt   = '0;
                end
            end
            STREAM: begin
                if (rd_ready) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = IDLE;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Captures pre-edge live values, so same-cycle increments or clear are excluded.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap <= '0;
        end else if (capture) begin
            snap <= live;
        end
    end

    assign rd_valid      = (state == STREAM);
    assign snap_busy     = rd_valid;
    assign rd_index      = idx;
    assign rd_last       = rd_valid && (idx == LAST_IDX);
    assign rd_data       = rd_valid ? snap[idx] : '0;
    assign clock_freq_hz = 64'(CORE_CLOCK_FREQUENCY_HZ);

endmodule

// File: tb/tb_cosim_event_counter_bank.sv
// Bench for cosim_event_counter_bank: a 64-bit wrap bank plus 8-bit wrap and
// 8-bit saturating banks sharing stimulus, checked by vector table and beat scoreboard.
module tb_cosim_event_counter_bank;

    localparam int NC = 4;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst, enable, clear, snap_req, rd_ready;
    logic [NC-1:0] event_in;

    always #5 clk = ~clk;

    logic          a_busy, a_valid, a_last, w_busy, w_valid, w_last, s_busy, s_valid, s_last;
    logic [IW-1:0] a_idx, w_idx, s_idx;
    logic [63:0]   a_data, a_freq, w_freq, s_freq;
    logic [7:0]    w_data, s_data;
    logic [NC:0]   a_ovf, w_ovf, s_ovf;

    cosim_event_counter_bank #(.NUM_CHANNELS(NC), .COUNT_WIDTH(64), .SATURATE(0)) u_a (
        .clk(clk), .rst(rst), .enable(enable), .event_in(event_in), .clear(clear),
        .snap_req(snap_req), .snap_busy(a_busy), .rd_valid(a_valid), .rd_ready(rd_ready),
        .rd_index(a_idx), .rd_data(a_data), .rd_last(a_last), .overflow(a_ovf),
        .clock_freq_hz(a_freq));

    cosim_event_counter_bank #(.NUM_CHANNELS(NC), .COUNT_WIDTH(8), .SATURATE(0)) u_w (
        .clk(clk), .rst(rst), .enable(enable), .event_in(event_in), .clear(clear),
        .snap_req(snap_req), .snap_busy(w_busy), .rd_valid(w_valid), .rd_ready(rd_ready),
        .rd_index(w_idx), .rd_data(w_data), .rd_last(w_last), .overflow(w_ovf),
        .clock_freq_hz(w_freq));

    cosim_event_counter_bank #(.NUM_CHANNELS(NC), .COUNT_WIDTH(8), .SATURATE(1)) u_s (
        .clk(clk), .rst(rst), .enable(enable), .event_in(event_in), .clear(clear),
        .snap_req(snap_req), .snap_busy(s_busy), .rd_valid(s_valid), .rd_ready(rd_ready),
        .rd_index(s_idx), .rd_data(s_data), .rd_last(s_last), .overflow(s_ovf),
        .clock_freq_hz(s_freq));

    typedef struct {
        int          idx;
        logic [63:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        logic        sr;
        logic        rr;
        logic        v;
        int          idx;
        logic [63:0] data;
        logic        last;
    } vec_t;

    beat_t    qa[$], qw[$], qs[$];
    vec_t     tbl[$];
    logic [2:0] mon_en;
    int       checks = 0;
    int       errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_snap(input int d, input logic [63:0] c0, c1, c2, c3, c4);
        logic [63:0] v[5];
        beat_t       b;
        v = '{c0, c1, c2, c3, c4};
        for (int i = 0; i < 5; i++) begin
            b.idx  = i;
            b.data = v[i];
            b.last = (i == 4);
            case (d)
                0:       qa.push_back(b);
                1:       qw.push_back(b);
                default: qs.push_back(b);
            endcase
        end
    endtask

    task automatic sb_check(input int d, input logic [IW-1:0] idx, input logic [63:0] data,
                            input logic last);
        beat_t e;
        int    n;
        n = (d == 0) ? qa.size() : (d == 1) ? qw.size() : qs.size();
        checks++;
        if (n == 0) begin
            errors++;
            $display("FAIL sb%0d_extra_beat: got index %0d, expected no beat", d, idx);
        end else begin
            case (d)
                0:       e = qa.pop_front();
                1:       e = qw.pop_front();
                default: e = qs.pop_front();
            endcase
            if (idx !== IW'(e.idx) || data !== e.data || last !== e.last) begin
                errors++;
                $display("FAIL sb%0d_beat: got (%0d,%0h,%0b) expected (%0d,%0h,%0b)",
                         d, idx, data, last, e.idx, e.data, e.last);
            end
        end
    endtask

    task automatic sb_empty(input string name);
        chk(name, 64'(qa.size() + qw.size() + qs.size()), 64'd0);
    endtask

    task automatic mon();
        if (mon_en[0] && a_valid && rd_ready) sb_check(0, a_idx, a_data, a_last);
        if (mon_en[1] && w_valid && rd_ready) sb_check(1, w_idx, 64'(w_data), w_last);
        if (mon_en[2] && s_valid && rd_ready) sb_check(2, s_idx, 64'(s_data), s_last);
    endtask

    task automatic sample();
        @(negedge clk);
        mon();
    endtask

    task automatic tick();
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        snap_req = 1'b1;
        enable   = 1'b0;
        tick();
        snap_req = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        rd_ready = 1'b1;
        while (a_busy && k < 20) begin
            tick();
            k++;
        end
        chk(name, 64'(a_busy), 64'd0);
    endtask

    function automatic logic [63:0] snapv(input int k);
        return (k == 0) ? 64'd10 : (k == 2) ? 64'd3 : 64'd0;
    endfunction

    task automatic row(input logic sr, rr, v, input int idx, input logic [63:0] d, input logic last);
        vec_t r;
        r = '{sr, rr, v, idx, d, last};
        tbl.push_back(r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach summary");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; clear = 1'b0; snap_req = 1'b0; rd_ready = 1'b0;
        event_in = '0; mon_en = 3'b000;
        @(posedge clk); #1;
        tick(); tick();

        chk("reset_valid", 64'(a_valid), 64'd0);
        chk("reset_busy", 64'(a_busy), 64'd0);
        chk("reset_last", 64'(a_last), 64'd0);
        chk("reset_index", 64'(a_idx), 64'd0);
        chk("reset_data", a_data, 64'd0);
        chk("reset_ovf", 64'(a_ovf), 64'd0);
        chk("reset_ovf_sat", 64'(s_ovf), 64'd0);
        chk("clock_freq", a_freq, 64'd100_000_000);

        // Basic count: 10 enabled cycles, event 1 pulsed three times.
        rst = 1'b0; enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            event_in = (i % 3 == 1) ? 4'b0010 : 4'b0000;
            tick();
        end
        enable = 1'b0; event_in = '0;

        row(1, 1, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) row(0, 1, 1, k, snapv(k), k == 4);
        row(0, 1, 0, 0, 0, 0);
        row(1, 1, 0, 0, 0, 0);
        row(0, 1, 1, 0, snapv(0), 0);
        for (int k = 1; k < 5; k++) begin
            row(0, 0, 1, k, snapv(k), k == 4);
            row((k == 1) ? 1'b1 : 1'b0, 0, 1, k, snapv(k), k == 4);
            row((k == 4) ? 1'b1 : 1'b0, 1, 1, k, snapv(k), k == 4);
        end
        row(0, 1, 0, 0, 0, 0);
        row(1, 1, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) row(0, 1, 1, k, snapv(k), k == 4);
        row(0, 1, 0, 0, 0, 0);

        mon_en = 3'b001;
        for (int s = 0; s < 3; s++) push_snap(0, 64'd10, 64'd0, 64'd3, 64'd0, 64'd0);
        foreach (tbl[i]) begin
            snap_req = tbl[i].sr;
            rd_ready = tbl[i].rr;
            sample();
            chk($sformatf("row%0d_valid", i), 64'(a_valid), 64'(tbl[i].v));
            chk($sformatf("row%0d_busy", i), 64'(a_busy), 64'(tbl[i].v));
            chk($sformatf("row%0d_index", i), 64'(a_idx), 64'(tbl[i].idx));
            chk($sformatf("row%0d_data", i), a_data, tbl[i].data);
            chk($sformatf("row%0d_last", i), 64'(a_last), 64'(tbl[i].last));
            @(posedge clk); #1;
        end
        snap_req = 1'b0;
        sb_empty("table_sb_empty");

        // 8-bit banks: 257 cycles wraps once / saturates.
        mon_en = 3'b110;
        clear = 1'b1; tick(); clear = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 257; i++) tick();
        enable = 1'b0;
        chk("wrap_ovf", 64'(w_ovf), 64'h01);
        chk("sat_cycle_ovf", 64'(s_ovf), 64'h01);
        push_snap(1, 64'd1, 64'd0, 64'd0, 64'd0, 64'd0);
        push_snap(2, 64'd255, 64'd0, 64'd0, 64'd0, 64'd0);
        snap(); drain("wrap_drain");
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clear_ovf", 64'(w_ovf), 64'd0);
        push_snap(1, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
        push_snap(2, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
        snap(); drain("clear_drain");
        sb_empty("wrap_sb_empty");

        // Channel 0 pulsed 300 times.
        clear = 1'b1; tick(); clear = 1'b0;
        enable = 1'b1; event_in = 4'b0001;
        for (int i = 0; i < 300; i++) tick();
        enable = 1'b0; event_in = '0;
        chk("sat_ovf", 64'(s_ovf), 64'h03);
        chk("wrap300_ovf", 64'(w_ovf), 64'h03);
        push_snap(2, 64'd255, 64'd255, 64'd0, 64'd0, 64'd0);
        push_snap(1, 64'd44, 64'd44, 64'd0, 64'd0, 64'd0);
        snap(); drain("sat_drain");
        sb_empty("sat_sb_empty");

        // Atomicity: snapshot with same-cycle event and clear, activity during stream.
        mon_en = 3'b001;
        clear = 1'b1; tick(); clear = 1'b0;
        enable = 1'b1; event_in = 4'b0100;
        for (int i = 0; i < 5; i++) tick();
        push_snap(0, 64'd5, 64'd0, 64'd0, 64'd5, 64'd0);
        snap_req = 1'b1; clear = 1'b1;
        tick();
        snap_req = 1'b0; event_in = 4'b1111;
        drain("atomic_drain");
        clear = 1'b0; enable = 1'b0; event_in = '0;
        chk("atomic_ovf", 64'(a_ovf), 64'd0);
        push_snap(0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
        snap(); drain("cleared_drain");
        sb_empty("atomic_sb_empty");

        // Reset in the middle of the stream.
        mon_en = 3'b000;
        clear = 1'b1; tick(); clear = 1'b0;
        enable = 1'b1; event_in = 4'b0010;
        for (int i = 0; i < 3; i++) tick();
        event_in = '0;
        snap();
        rd_ready = 1'b1; tick(); tick();
        chk("mid_valid", 64'(a_valid), 64'd1);
        chk("mid_index", 64'(a_idx), 64'd2);
        chk("mid_data", a_data, 64'd3);
        rst = 1'b1; rd_ready = 1'b0; tick(); rst = 1'b0;
        chk("rst_mid_valid", 64'(a_valid), 64'd0);
        chk("rst_mid_busy", 64'(a_busy), 64'd0);
        chk("rst_mid_index", 64'(a_idx), 64'd0);
        enable = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        mon_en = 3'b001;
        push_snap(0, 64'd4, 64'd0, 64'd0, 64'd0, 64'd0);
        snap(); drain("post_rst_drain");
        sb_empty("post_rst_sb_empty");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
